// File: rtl/nios2_debug_slave_sysclk_multi_if.sv
// Bus bundle between the TCK-side debug logic and the system-clock debug slave.
// The slave modport belongs to the debug slave; the master modport belongs to whoever drives it.
`timescale 1ns/1ps
interface nios2_debug_slave_sysclk_multi_if #(
  parameter int SR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int FIFO_DEPTH = 4
);
  localparam int NCH = 1 << IR_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  logic                vs_uir;
  logic                vs_udr;
  logic [IR_WIDTH-1:0] ir_in;
  logic [SR_WIDTH-1:0] sr;
  logic                cmd_ready;
  logic                clear_ovf;
  logic                cmd_valid;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [SR_WIDTH-1:0] cmd_data;
  logic [SR_WIDTH-1:0] jdo;
  logic [NCH-1:0]      take_action;
  logic [NCH-1:0]      take_no_action;
  logic [CW-1:0]       fifo_count;
  logic                overflow;

  modport slave (
    input  vs_uir, vs_udr, ir_in, sr, cmd_ready, clear_ovf,
    output cmd_valid, cmd_ir, cmd_data, jdo, take_action, take_no_action, fifo_count, overflow
  );

  modport master (
    output vs_uir, vs_udr, ir_in, sr, cmd_ready, clear_ovf,
    input  cmd_valid, cmd_ir, cmd_data, jdo, take_action, take_no_action, fifo_count, overflow
  );
endinterface

// File: rtl/nios2_debug_slave_sysclk_multi.sv
// System-clock side of the Nios II JTAG debug slave: synchronises update-IR/update-DR strobes,
// buffers update-DR scans in a command FIFO and decodes popped commands into action strobes.
`timescale 1ns/1ps
module nios2_debug_slave_sysclk_multi #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACTION_BIT  = 34
) (
  input  logic clk,
  input  logic reset_n,
  nios2_debug_slave_sysclk_multi_if.slave bus
);
  localparam int NCH = 1 << IR_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  // Strobe channel 0 is update-IR, channel 1 is update-DR.
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES:0]        fill_q, fill_d;
  logic [1:0]                  lvl_q, lvl_d;
  logic [1:0]                  prev_q, prev_d;
  logic [1:0]                  arm_q, arm_d;
  logic [1:0]                  evt_q, evt_d;
  logic [1:0]                  strb_raw_s;

  logic [SR_WIDTH-1:0] dmem_q [FIFO_DEPTH];
  logic [SR_WIDTH-1:0] dmem_d [FIFO_DEPTH];
  logic [IR_WIDTH-1:0] imem_q [FIFO_DEPTH];
  logic [IR_WIDTH-1:0] imem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [IR_WIDTH-1:0] ir_q, ir_d;
  logic                overflow_q, overflow_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic [IR_WIDTH-1:0] cmd_ir_q, cmd_ir_d;
  logic [SR_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic [SR_WIDTH-1:0] jdo_q, jdo_d;
  logic [NCH-1:0]      ta_q, ta_d, tna_q, tna_d;
  logic                push_s, pop_s, full_s, acc_s, drop_s;

  // Synchroniser, registered edge detector and arming for both strobes.
  // fill_q marks when lvl_q first holds a genuinely sampled value after reset,
  // so a strobe held high through reset release never arms.
  always_comb begin
    strb_raw_s = {bus.vs_udr, bus.vs_uir};
    fill_d     = {fill_q[SYNC_STAGES-1:0], 1'b1};
    sync_d     = sync_q;
    lvl_d      = lvl_q;
    prev_d     = lvl_q;
    arm_d      = arm_q;
    evt_d      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], strb_raw_s[i]};
      lvl_d[i]  = sync_q[i][SYNC_STAGES-1];
      arm_d[i]  = arm_q[i] | (fill_q[SYNC_STAGES] & ~lvl_q[i]);
      evt_d[i]  = lvl_q[i] & ~prev_q[i] & arm_q[i];
    end
  end

  // Command FIFO, IR register, overflow flag and popped-command decode.
  always_comb begin
    push_s     = evt_q[1];
    pop_s      = cmd_valid_q & bus.cmd_ready;
    full_s     = (count_q == CW'(FIFO_DEPTH));
    acc_s      = push_s & (~full_s | pop_s);
    drop_s     = push_s & full_s & ~pop_s;
    dmem_d     = dmem_q;
    imem_d     = imem_q;
    ir_d       = evt_q[0] ? bus.ir_in : ir_q;
    jdo_d      = jdo_q;
    ta_d       = {NCH{1'b0}};
    tna_d      = {NCH{1'b0}};
    if (acc_s) begin
      dmem_d[wr_ptr_q] = bus.sr;
      imem_d[wr_ptr_q] = ir_q;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      jdo_d    = cmd_data_q;
      if (cmd_data_q[ACTION_BIT]) begin
        ta_d[cmd_ir_q] = 1'b1;
      end else begin
        tna_d[cmd_ir_q] = 1'b1;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({acc_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (bus.clear_ovf) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
    cmd_valid_d = (count_d != {CW{1'b0}});
    cmd_data_d  = dmem_d[rd_ptr_d];
    cmd_ir_d    = imem_d[rd_ptr_d];
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      fill_q      <= {(SYNC_STAGES+1){1'b0}};
      lvl_q       <= 2'b00;
      prev_q      <= 2'b00;
      arm_q       <= 2'b00;
      evt_q       <= 2'b00;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        dmem_q[i] <= {SR_WIDTH{1'b0}};
        imem_q[i] <= {IR_WIDTH{1'b0}};
      end
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      ir_q        <= {IR_WIDTH{1'b0}};
      overflow_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_ir_q    <= {IR_WIDTH{1'b0}};
      cmd_data_q  <= {SR_WIDTH{1'b0}};
      jdo_q       <= {SR_WIDTH{1'b0}};
      ta_q        <= {NCH{1'b0}};
      tna_q       <= {NCH{1'b0}};
    end else begin
      sync_q      <= sync_d;
      fill_q      <= fill_d;
      lvl_q       <= lvl_d;
      prev_q      <= prev_d;
      arm_q       <= arm_d;
      evt_q       <= evt_d;
      dmem_q      <= dmem_d;
      imem_q      <= imem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ir_q        <= ir_d;
      overflow_q  <= overflow_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_ir_q    <= cmd_ir_d;
      cmd_data_q  <= cmd_data_d;
      jdo_q       <= jdo_d;
      ta_q        <= ta_d;
      tna_q       <= tna_d;
    end
  end

  assign bus.cmd_valid      = cmd_valid_q;
  assign bus.cmd_ir         = cmd_ir_q;
  assign bus.cmd_data       = cmd_data_q;
  assign bus.jdo            = jdo_q;
  assign bus.take_action    = ta_q;
  assign bus.take_no_action = tna_q;
  assign bus.fifo_count     = count_q;
  assign bus.overflow       = overflow_q;
endmodule

// File: tb/tb_nios2_debug_slave_sysclk_multi.sv
// Directed bench for nios2_debug_slave_sysclk_multi; inputs change and outputs are sampled on clk negedge.
`timescale 1ns/1ps
module tb_nios2_debug_slave_sysclk_multi;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  nios2_debug_slave_sysclk_multi_if #(.SR_WIDTH(38), .IR_WIDTH(2), .FIFO_DEPTH(4)) bus ();

  nios2_debug_slave_sysclk_multi #(
    .SR_WIDTH(38), .IR_WIDTH(2), .SYNC_STAGES(2), .FIFO_DEPTH(4), .ACTION_BIT(34)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset(input logic udr_level);
    @(negedge clk);
    reset_n       = 1'b0;
    bus.vs_uir    = 1'b0;
    bus.vs_udr    = udr_level;
    bus.cmd_ready = 1'b0;
    bus.clear_ovf = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic scan_ir(input logic [1:0] v);
    bus.ir_in  = v;
    bus.vs_uir = 1'b1;
    repeat (4) @(negedge clk);
    bus.vs_uir = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic scan_dr(input logic [37:0] v);
    bus.sr     = v;
    bus.vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.cmd_valid, bus.fifo_count, bus.overflow, bus.take_action, bus.take_no_action} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b expected 0",
               {bus.cmd_valid, bus.fifo_count, bus.overflow, bus.take_action, bus.take_no_action});
    end
    n_cmp++;
    if ({bus.jdo, bus.cmd_data, bus.cmd_ir} !== 78'd0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", {bus.jdo, bus.cmd_data, bus.cmd_ir});
    end
    do_reset(1'b0);
  endtask

  task automatic test_action;
    scan_ir(2'd2);
    bus.cmd_ready = 1'b1;
    bus.sr        = 38'h04_0000_1234;
    bus.vs_udr    = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (bus.cmd_valid !== 1'b0) begin
      n_bad++; $display("FAIL act_early_valid: got %b expected 0", bus.cmd_valid);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.cmd_valid, bus.cmd_ir, bus.cmd_data} !== {1'b1, 2'd2, 38'h04_0000_1234}) begin
      n_bad++;
      $display("FAIL act_head: got %b/%0d/%h expected 1/2/0400001234", bus.cmd_valid, bus.cmd_ir, bus.cmd_data);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.take_action, bus.take_no_action} !== 8'b0100_0000) begin
      n_bad++;
      $display("FAIL act_strobe: got %b/%b expected 0100/0000", bus.take_action, bus.take_no_action);
    end
    n_cmp++;
    if (bus.jdo !== 38'h04_0000_1234) begin
      n_bad++; $display("FAIL act_jdo: got %h expected 0400001234", bus.jdo);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.take_action, bus.cmd_valid} !== 5'b0) begin
      n_bad++; $display("FAIL act_one_cycle: got %b/%b expected 0000/0", bus.take_action, bus.cmd_valid);
    end
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_no_action;
    bit seen;
    scan_ir(2'd0);
    bus.cmd_ready = 1'b1;
    bus.sr        = 38'h00_0000_00AA;
    bus.vs_udr    = 1'b1;
    seen          = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (bus.take_no_action !== 4'b0000 || bus.take_action !== 4'b0000) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++; $display("FAIL noact_timeout: got no strobe expected strobe within 12 cycles");
    end else if ({bus.take_action, bus.take_no_action} !== 8'b0000_0001) begin
      n_bad++;
      $display("FAIL noact_strobe: got %b/%b expected 0000/0001", bus.take_action, bus.take_no_action);
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.take_action, bus.take_no_action, bus.jdo} !== {8'b0, 38'h00_0000_00AA}) begin
      n_bad++;
      $display("FAIL noact_after: got %b/%b/%h expected 0000/0000/00000000aa",
               bus.take_action, bus.take_no_action, bus.jdo);
    end
    bus.vs_udr    = 1'b0;
    bus.cmd_ready = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 5; i++) scan_dr(38'(i));
    n_cmp++;
    if ({bus.fifo_count, bus.overflow, bus.cmd_data} !== {3'd4, 1'b1, 38'd1}) begin
      n_bad++;
      $display("FAIL ovf_full: got cnt=%0d ovf=%b head=%h expected 4/1/1", bus.fifo_count, bus.overflow, bus.cmd_data);
    end
    bus.cmd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      n_cmp++;
      if ({bus.cmd_valid, bus.cmd_data} !== {1'b1, 38'(i)}) begin
        n_bad++; $display("FAIL ovf_pop_head: got %b/%h expected 1/%h", bus.cmd_valid, bus.cmd_data, 38'(i));
      end
      @(negedge clk);
      n_cmp++;
      if (bus.jdo !== 38'(i)) begin
        n_bad++; $display("FAIL ovf_pop_jdo: got %h expected %h", bus.jdo, 38'(i));
      end
      if (i == 1) begin
        n_cmp++;
        if (bus.take_no_action !== 4'b0001) begin
          n_bad++; $display("FAIL ovf_pop_strobe: got %b expected 0001", bus.take_no_action);
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.cmd_valid, bus.fifo_count, bus.take_action, bus.take_no_action, bus.jdo} !== {12'b0, 38'd4}) begin
      n_bad++;
      $display("FAIL ovf_empty: got v=%b cnt=%0d ta=%b tna=%b jdo=%h expected 0/0/0/0/4",
               bus.cmd_valid, bus.fifo_count, bus.take_action, bus.take_no_action, bus.jdo);
    end
    bus.cmd_ready = 1'b0;
    bus.clear_ovf = 1'b1;
    @(negedge clk);
    bus.clear_ovf = 1'b0;
    n_cmp++;
    if (bus.overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_clear: got %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_full_push_pop;
    logic [37:0] exp_q [4];
    exp_q = '{38'd11, 38'd12, 38'd13, 38'd14};
    for (int i = 10; i <= 13; i++) scan_dr(38'(i));
    bus.sr     = 38'd14;
    bus.vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    n_cmp++;
    if ({bus.fifo_count, bus.overflow, bus.cmd_data, bus.jdo} !== {3'd4, 1'b0, 38'd11, 38'd10}) begin
      n_bad++;
      $display("FAIL fpp_state: got cnt=%0d ovf=%b head=%h jdo=%h expected 4/0/b/a",
               bus.fifo_count, bus.overflow, bus.cmd_data, bus.jdo);
    end
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (bus.cmd_data !== exp_q[i]) begin
        n_bad++; $display("FAIL fpp_order: got %h expected %h", bus.cmd_data, exp_q[i]);
      end
      @(negedge clk);
    end
    bus.cmd_ready = 1'b0;
    n_cmp++;
    if ({bus.fifo_count, bus.overflow, bus.jdo} !== {3'd0, 1'b0, 38'd14}) begin
      n_bad++;
      $display("FAIL fpp_drained: got cnt=%0d ovf=%b jdo=%h expected 0/0/e", bus.fifo_count, bus.overflow, bus.jdo);
    end
  endtask

  task automatic test_held_through_reset;
    scan_dr(38'd7);
    n_cmp++;
    if (bus.fifo_count !== 3'd1) begin
      n_bad++; $display("FAIL hold_prefill: got %0d expected 1", bus.fifo_count);
    end
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({bus.cmd_valid, bus.fifo_count} !== 4'b0) begin
      n_bad++; $display("FAIL hold_no_event: got v=%b cnt=%0d expected 0/0", bus.cmd_valid, bus.fifo_count);
    end
    bus.vs_udr = 1'b0;
    repeat (5) @(negedge clk);
    bus.sr = 38'd9;
    bus.vs_udr = 1'b1;
    repeat (8) @(negedge clk);
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({bus.fifo_count, bus.cmd_data} !== {3'd1, 38'd9}) begin
      n_bad++; $display("FAIL hold_fresh_edge: got cnt=%0d head=%h expected 1/9", bus.fifo_count, bus.cmd_data);
    end
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
  endtask

  task automatic test_simultaneous;
    scan_ir(2'd1);
    bus.ir_in  = 2'd3;
    bus.sr     = 38'h21;
    bus.vs_uir = 1'b1;
    bus.vs_udr = 1'b1;
    repeat (4) @(negedge clk);
    bus.vs_uir = 1'b0;
    bus.vs_udr = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({bus.cmd_ir, bus.cmd_data} !== {2'd1, 38'h21}) begin
      n_bad++; $display("FAIL sim_old_ir: got ir=%0d data=%h expected 1/21", bus.cmd_ir, bus.cmd_data);
    end
    scan_dr(38'h22);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    n_cmp++;
    if ({bus.take_no_action, bus.jdo} !== {4'b0010, 38'h21}) begin
      n_bad++; $display("FAIL sim_pop: got tna=%b jdo=%h expected 0010/21", bus.take_no_action, bus.jdo);
    end
    n_cmp++;
    if ({bus.cmd_ir, bus.cmd_data, bus.fifo_count} !== {2'd3, 38'h22, 3'd1}) begin
      n_bad++;
      $display("FAIL sim_new_ir: got ir=%0d data=%h cnt=%0d expected 3/22/1", bus.cmd_ir, bus.cmd_data, bus.fifo_count);
    end
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    bus.vs_uir    = 1'b0;
    bus.vs_udr    = 1'b0;
    bus.ir_in     = 2'd0;
    bus.sr        = 38'd0;
    bus.cmd_ready = 1'b0;
    bus.clear_ovf = 1'b0;
    test_reset();
    test_action();
    test_no_action();
    test_overflow();
    test_full_push_pop();
    test_held_through_reset();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
